// File: rtl/vram_pixel_fetch_if.sv
// VRAM read bus between the pixel fetcher and the six bit-plane memories.
// One shared 13-bit address; the plane bytes return one clock later.
interface vram_pixel_fetch_if;
  logic [12:0] vdp_addr;
  logic [7:0]  fg1;
  logic [7:0]  fg2;
  logic [7:0]  fg3;
  logic [7:0]  bg1;
  logic [7:0]  bg2;
  logic [7:0]  bg3;

  modport master (
    output vdp_addr,
    input  fg1, fg2, fg3, bg1, bg2, bg3
  );

  modport slave (
    input  vdp_addr,
    output fg1, fg2, fg3, bg1, bg2, bg3
  );
endinterface

// File: rtl/vram_pixel_fetch.sv
// Display-side VRAM fetch: addresses the bit-plane VRAMs for each active line
// and serializes fg/bg plane bytes into per-pixel 3-bit colour indices.
module vram_pixel_fetch #(
  parameter int H_START = 64,
  parameter int V_START = 24,
  parameter int H_BYTES = 24,
  parameter int V_LINES = 184
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce_pix,
  input  logic [8:0]         h,
  input  logic [8:0]         v,
  vram_pixel_fetch_if.master vram,
  output logic [2:0]         fg_idx,
  output logic [2:0]         bg_idx,
  output logic               de,
  output logic               line_end
);

  typedef enum logic {S_WAIT, S_ACTIVE} state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  col;
  logic [2:0]  bitc;
  logic [7:0]  fgsr1, fgsr2, fgsr3;
  logic [7:0]  bgsr1, bgsr2, bgsr3;
  logic [7:0]  row;
  logic [12:0] row_w;
  logic [12:0] base;
  logic        in_window;
  logic        load_first;
  logic        load_next;
  logic        shift_en;
  logic        finish;

  // v[8] only matters for the window test, so the row offset fits in 8 bits
  assign row       = v[7:0] - 8'(V_START);
  assign row_w     = {5'd0, row};
  assign base      = (row_w << 4) + (row_w << 3);
  assign in_window = (v >= 9'(V_START)) && (v < 9'(V_START + V_LINES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_WAIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    de         = 1'b0;
    fg_idx     = 3'd0;
    bg_idx     = 3'd0;
    load_first = 1'b0;
    load_next  = 1'b0;
    shift_en   = 1'b0;
    finish     = 1'b0;
    case (state)
      S_WAIT: begin
        if (ce_pix && (h == 9'(H_START - 1)) && in_window) begin
          load_first = 1'b1;
          state_next = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        de     = 1'b1;
        fg_idx = {fgsr3[0], fgsr2[0], fgsr1[0]};
        bg_idx = {bgsr3[0], bgsr2[0], bgsr1[0]};
        if (ce_pix) begin
          if (bitc != 3'd7) begin
            shift_en = 1'b1;
          end else if (col != 5'(H_BYTES - 1)) begin
            load_next = 1'b1;
          end else begin
            finish     = 1'b1;
            state_next = S_WAIT;
          end
        end
      end
      default: state_next = S_WAIT;
    endcase
  end

  // The address always runs one byte ahead of the shift registers so the
  // next byte is already on the bus when the current one is used up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col           <= 5'd0;
      bitc          <= 3'd0;
      fgsr1         <= 8'd0;
      fgsr2         <= 8'd0;
      fgsr3         <= 8'd0;
      bgsr1         <= 8'd0;
      bgsr2         <= 8'd0;
      bgsr3         <= 8'd0;
      vram.vdp_addr <= 13'd0;
      line_end      <= 1'b0;
    end else begin
      line_end <= finish;
      if (load_first || load_next) begin
        fgsr1 <= vram.fg1;
        fgsr2 <= vram.fg2;
        fgsr3 <= vram.fg3;
        bgsr1 <= vram.bg1;
        bgsr2 <= vram.bg2;
        bgsr3 <= vram.bg3;
        bitc  <= 3'd0;
      end else if (shift_en) begin
        fgsr1 <= fgsr1 >> 1;
        fgsr2 <= fgsr2 >> 1;
        fgsr3 <= fgsr3 >> 1;
        bgsr1 <= bgsr1 >> 1;
        bgsr2 <= bgsr2 >> 1;
        bgsr3 <= bgsr3 >> 1;
        bitc  <= bitc + 3'd1;
      end
      if (load_first) begin
        col           <= 5'd0;
        vram.vdp_addr <= base + 13'd1;
      end else if (load_next) begin
        col <= col + 5'd1;
        // once the last byte of the row is addressed the bus is held there
        if (col < 5'(H_BYTES - 2)) begin
          vram.vdp_addr <= base + {8'd0, col} + 13'd2;
        end
      end else if (state == S_WAIT) begin
        vram.vdp_addr <= in_window ? base : 13'd0;
      end
    end
  end

endmodule

// File: tb/tb_vram_pixel_fetch.sv
// Self-checking bench for vram_pixel_fetch: registered VRAM model, video
// counter driver and a per-pixel scoreboard fed from a reference pixel model.
module tb_vram_pixel_fetch;

  localparam int H_START = 64;
  localparam int V_START = 24;
  localparam int H_BYTES = 24;
  localparam int V_LINES = 184;

  typedef struct packed {
    logic       de;
    logic [2:0] fg;
    logic [2:0] bg;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce_pix;
  logic [8:0] h;
  logic [8:0] v;
  logic [2:0] fg_idx;
  logic [2:0] bg_idx;
  logic       de;
  logic       line_end;

  int checks = 0;
  int failures = 0;
  int de_count = 0;
  int le_count = 0;

  logic [7:0]  mem [0:5][0:8191];
  pix_t        sb [$];
  logic [12:0] addr_seq [$];
  logic [2:0]  fg_obs [0:511];
  logic [2:0]  bg_obs [0:511];
  logic        de_obs [0:511];

  vram_pixel_fetch_if vif ();

  vram_pixel_fetch #(
    .H_START(H_START),
    .V_START(V_START),
    .H_BYTES(H_BYTES),
    .V_LINES(V_LINES)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce_pix  (ce_pix),
    .h       (h),
    .v       (v),
    .vram    (vif.master),
    .fg_idx  (fg_idx),
    .bg_idx  (bg_idx),
    .de      (de),
    .line_end(line_end)
  );

  always #5 clk = ~clk;

  // registered VRAM: data follows the address by one clock
  always @(posedge clk) begin
    vif.fg1 <= mem[0][vif.vdp_addr];
    vif.fg2 <= mem[1][vif.vdp_addr];
    vif.fg3 <= mem[2][vif.vdp_addr];
    vif.bg1 <= mem[3][vif.vdp_addr];
    vif.bg2 <= mem[4][vif.vdp_addr];
    vif.bg3 <= mem[5][vif.vdp_addr];
  end

  function automatic pix_t ref_pixel(input int vv, input int hh);
    pix_t p;
    int r, n, a, b;
    p = '0;
    if (vv >= V_START && vv < V_START + V_LINES && hh >= H_START && hh < H_START + 8 * H_BYTES) begin
      r = vv - V_START;
      n = hh - H_START;
      a = r * H_BYTES + n / 8;
      b = n % 8;
      p.de = 1'b1;
      p.fg = {mem[2][a][b], mem[1][a][b], mem[0][a][b]};
      p.bg = {mem[5][a][b], mem[4][a][b], mem[3][a][b]};
    end
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (line_end === 1'b1) le_count++;
  endtask

  task automatic clear_mem();
    for (int p = 0; p < 6; p++)
      for (int i = 0; i < 8192; i++)
        mem[p][i] = 8'd0;
  endtask

  task automatic fill_random();
    for (int p = 0; p < 6; p++)
      for (int i = 0; i < 8192; i++)
        mem[p][i] = 8'($urandom);
  endtask

  task automatic record_obs();
    fg_obs[h] = fg_idx;
    bg_obs[h] = bg_idx;
    de_obs[h] = de;
    if (de === 1'b1) de_count++;
    if (h <= 9'(H_START + 8 * H_BYTES) && vif.vdp_addr !== addr_seq[$])
      addr_seq.push_back(vif.vdp_addr);
  endtask

  // one line from h=H_START-1; each ce pushes the expected pixel for the new h
  task automatic run_line(input int vv, input int period, input int stop_h);
    pix_t got;
    pix_t exp_p;
    logic [8:0] h_next;
    for (int i = 0; i < 512; i++) begin
      fg_obs[i] = 3'd0;
      bg_obs[i] = 3'd0;
      de_obs[i] = 1'b0;
    end
    addr_seq.delete();
    v = 9'(vv);
    h = 9'(H_START - 1);
    ce_pix = 1'b0;
    repeat (2) tick();
    addr_seq.push_back(vif.vdp_addr);
    fg_obs[h] = fg_idx;
    bg_obs[h] = bg_idx;
    de_obs[h] = de;
    for (int p = 0; p < 8 * H_BYTES + 2; p++) begin
      h_next = h + 9'd1;
      sb.push_back(ref_pixel(vv, int'(h_next)));
      ce_pix = 1'b1;
      tick();
      ce_pix = 1'b0;
      h = h_next;
      got = {de, fg_idx, bg_idx};
      exp_p = sb.pop_front();
      checks++;
      if (got !== exp_p) begin
        failures++;
        $display("[TB] FAIL pixel v=%0d h=%0d got de/fg/bg=%b/%b/%b exp=%b/%b/%b",
                 vv, h, got.de, got.fg, got.bg, exp_p.de, exp_p.fg, exp_p.bg);
      end
      record_obs();
      if (stop_h != 0 && int'(h) == stop_h) return;
      repeat (period - 1) tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ce_pix  = 1'b0;
    h       = 9'd0;
    v       = 9'd0;
    clear_mem();
    repeat (2) tick();
    checks++;
    if (de !== 1'b0 || line_end !== 1'b0 || vif.vdp_addr !== 13'd0 || fg_idx !== 3'd0 || bg_idx !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_values got de=%b le=%b addr=%0d fg=%b bg=%b exp all zero",
               de, line_end, vif.vdp_addr, fg_idx, bg_idx);
    end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_first_pixel();
    clear_mem();
    mem[0][0] = 8'h01;
    run_line(V_START, 2, 0);
    checks++;
    if (fg_obs[H_START] !== 3'b001) begin
      failures++;
      $display("[TB] FAIL row0_first_fg got=%b exp=001", fg_obs[H_START]);
    end
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (fg_obs[H_START + i] !== 3'b000) begin
        failures++;
        $display("[TB] FAIL row0_fg_h%0d got=%b exp=000", H_START + i, fg_obs[H_START + i]);
      end
    end
    checks++;
    if (de_obs[H_START - 1] !== 1'b0 || de_obs[H_START] !== 1'b1 ||
        de_obs[H_START + 191] !== 1'b1 || de_obs[H_START + 192] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL de_edges got=%b%b%b%b exp=0110", de_obs[H_START - 1], de_obs[H_START],
               de_obs[H_START + 191], de_obs[H_START + 192]);
    end
  endtask

  task automatic test_row5_pattern();
    clear_mem();
    mem[2][5 * 24 + 2] = 8'h80;
    mem[4][5 * 24 + 2] = 8'hFF;
    run_line(V_START + 5, 2, 0);
    checks++;
    if (fg_obs[H_START + 23] !== 3'b100 || fg_obs[H_START + 22] !== 3'b000) begin
      failures++;
      $display("[TB] FAIL row5_fg got h87=%b h86=%b exp 100/000", fg_obs[H_START + 23], fg_obs[H_START + 22]);
    end
    for (int i = 15; i <= 24; i++) begin
      checks++;
      if (bg_obs[H_START + i] !== ((i >= 16 && i <= 23) ? 3'b010 : 3'b000)) begin
        failures++;
        $display("[TB] FAIL row5_bg_h%0d got=%b exp=%b", H_START + i, bg_obs[H_START + i],
                 (i >= 16 && i <= 23) ? 3'b010 : 3'b000);
      end
    end
    checks++;
    if (addr_seq.size() != 24) begin
      failures++;
      $display("[TB] FAIL row5_addr_count got=%0d exp=24", addr_seq.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        checks++;
        if (addr_seq[i] !== 13'(120 + i)) begin
          failures++;
          $display("[TB] FAIL row5_addr_%0d got=%0d exp=%0d", i, addr_seq[i], 120 + i);
        end
      end
    end
  endtask

  task automatic test_last_rows();
    int line_de;
    fill_random();
    run_line(V_START + 183, 2, 0);
    checks++;
    if (addr_seq[0] !== 13'd4392 || addr_seq[$] !== 13'd4415) begin
      failures++;
      $display("[TB] FAIL row183_addr got first=%0d last=%0d exp 4392/4415", addr_seq[0], addr_seq[$]);
    end
    run_line(V_START + 184, 2, 0);
    line_de = 0;
    for (int i = 0; i < 512; i++) if (de_obs[i] === 1'b1) line_de++;
    checks++;
    if (line_de != 0) begin
      failures++;
      $display("[TB] FAIL below_window_de got=%0d exp=0", line_de);
    end
    checks++;
    if (addr_seq.size() != 1 || addr_seq[0] !== 13'd0) begin
      failures++;
      $display("[TB] FAIL below_window_addr got size=%0d addr=%0d exp 1/0", addr_seq.size(), addr_seq[0]);
    end
  endtask

  task automatic test_reset_mid_line();
    fill_random();
    run_line(V_START + 10, 2, H_START + 50);
    reset_n = 1'b0;
    #1;
    checks++;
    if (de !== 1'b0 || vif.vdp_addr !== 13'd0 || fg_idx !== 3'd0 || bg_idx !== 3'd0) begin
      failures++;
      $display("[TB] FAIL mid_line_reset got de=%b addr=%0d fg=%b bg=%b exp 0/0/0/0",
               de, vif.vdp_addr, fg_idx, bg_idx);
    end
    tick();
    reset_n = 1'b1;
    tick();
    run_line(V_START + 11, 2, 0);
    checks++;
    if (de_obs[H_START] !== 1'b1 || de_obs[H_START - 1] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL resume_after_reset got de63=%b de64=%b exp 0/1", de_obs[H_START - 1], de_obs[H_START]);
    end
  endtask

  task automatic test_full_frame();
    fill_random();
    de_count = 0;
    le_count = 0;
    for (int r = 0; r < V_LINES; r++)
      run_line(V_START + r, (r % 23 == 0) ? 4 : 2, 0);
    tick();
    checks++;
    if (de_count != 35328) begin
      failures++;
      $display("[TB] FAIL frame_de_count got=%0d exp=35328", de_count);
    end
    checks++;
    if (le_count != 184) begin
      failures++;
      $display("[TB] FAIL frame_line_end_count got=%0d exp=184", le_count);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_first_pixel();
    test_row5_pattern();
    test_last_rows();
    test_reset_mid_line();
    test_full_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
